rbus_vga_eve_seq: RTL

- Event-side controller for the RBUS VGA box.
- Turns a one-shot "apply display configuration" request into the ordered series of VGA config events.
- Drains a local character FIFO as PUT_CHAR events, and arbitrates both onto the single event channel that feeds the VGA box's r2d_eve_* inputs.
- Sits between a local host/boot sequencer and the VGA box.

---
 rtl/rbus_vga_eve_seq.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/rbus_vga_eve_seq.sv
// Event-side sequencer for the RBUS VGA box: plays a captured display
// configuration as an ordered series of config events and drains a local
// character FIFO as PUT_CHAR events, all on one strobe/ack event channel.
module rbus_vga_eve_seq #(
    parameter int TXT_FIFO_AW = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_req,
    input  logic [38:0]            cfg_base_addr,
    input  logic [15:0]            cfg_ph_width,
    input  logic [15:0]            cfg_lo_width,
    input  logic [15:0]            cfg_lo_height,
    input  logic [1:0]             cfg_mode,
    input  logic                   cfg_text_ena,
    input  logic                   cfg_h_pol,
    input  logic                   cfg_v_pol,
    output logic                   cfg_busy,
    output logic                   cfg_done,
    input  logic                   txt_stb,
    input  logic [7:0]             txt_data,
    output logic                   txt_rdy,
    output logic [TXT_FIFO_AW:0]   txt_level,
    output logic                   eve_stb,
    output logic [7:0]             eve_cmd,
    output logic [39:0]            eve_ptr,
    input  logic                   eve_ack
);

    localparam int DEPTH = 2 ** TXT_FIFO_AW;
    localparam logic [TXT_FIFO_AW:0] FULL_LEVEL = (TXT_FIFO_AW + 1)'(DEPTH);
    localparam logic [3:0] LAST_IDX = 4'd8;
    localparam logic [3:0] END_IDX  = 4'd9;

    typedef enum logic [2:0] {
        IDLE,
        CFG,
        CGAP,
        TXT,
        TGAP
    } state_t;

    state_t state;
    state_t next_state;

    logic [38:0] base_q;
    logic [15:0] ph_width_q;
    logic [15:0] lo_width_q;
    logic [15:0] lo_height_q;
    logic [1:0]  mode_q;
    logic        text_ena_q;
    logic        h_pol_q;
    logic        v_pol_q;
    logic [3:0]  cfg_idx;

    logic [7:0]             fifo_mem [DEPTH];
    logic [TXT_FIFO_AW-1:0] wr_ptr;
    logic [TXT_FIFO_AW-1:0] rd_ptr;

    logic xfer;
    logic cfg_xfer;
    logic push;
    logic pop;

    assign xfer     = eve_stb && eve_ack;
    assign cfg_xfer = xfer && (state == CFG);
    assign pop      = xfer && (state == TXT);
    assign txt_rdy  = (txt_level != FULL_LEVEL);
    assign push     = txt_stb && txt_rdy;

    // Latch a config request when idle and track busy/done around the sequence
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q      <= '0;
            ph_width_q  <= '0;
            lo_width_q  <= '0;
            lo_height_q <= '0;
            mode_q      <= '0;
            text_ena_q  <= 1'b0;
            h_pol_q     <= 1'b0;
            v_pol_q     <= 1'b0;
            cfg_busy    <= 1'b0;
            cfg_done    <= 1'b0;
        end else begin
            cfg_done <= 1'b0;
            if (cfg_req && !cfg_busy) begin
                base_q      <= cfg_base_addr;
                ph_width_q  <= cfg_ph_width;
                lo_width_q  <= cfg_lo_width;
                lo_height_q <= cfg_lo_height;
                mode_q      <= cfg_mode;
                text_ena_q  <= cfg_text_ena;
                h_pol_q     <= cfg_h_pol;
                v_pol_q     <= cfg_v_pol;
                cfg_busy    <= 1'b1;
            end else if (cfg_xfer && (cfg_idx == LAST_IDX)) begin
                cfg_busy <= 1'b0;
                cfg_done <= 1'b1;
            end
        end
    end

    // Config event index: restarts from zero whenever the sequencer is idle
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_idx <= '0;
        end else if (state == IDLE) begin
            cfg_idx <= '0;
        end else if (cfg_xfer) begin
            cfg_idx <= cfg_idx + 4'd1;
        end
    end

    // Character storage; contents need no reset since the pointers gate reads
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= txt_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the depth
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            txt_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   txt_level <= txt_level + 1'b1;
                2'b01:   txt_level <= txt_level - 1'b1;
                default: txt_level <= txt_level;
            endcase
        end
    end

    // State register, with the strobe registered from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            eve_stb <= 1'b0;
        end else begin
            state   <= next_state;
            eve_stb <= (next_state == CFG) || (next_state == TXT);
        end
    end

    // Next state: config wins at every idle decision, events are never preempted
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (cfg_busy) begin
                    next_state = CFG;
                end else if (txt_level != '0) begin
                    next_state = TXT;
                end
            end
            CFG: begin
                if (xfer) begin
                    next_state = CGAP;
                end
            end
            CGAP: begin
                if (cfg_idx == END_IDX) begin
                    next_state = IDLE;
                end else begin
                    next_state = CFG;
                end
            end
            TXT: begin
                if (xfer) begin
                    next_state = TGAP;
                end
            end
            TGAP: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Event payload: held stable by the state, index and FIFO head until transfer
    always_comb begin
        eve_cmd = 8'h00;
        eve_ptr = 40'd0;
        if (state == CFG) begin
            case (cfg_idx)
                4'd0: begin eve_cmd = 8'h25; eve_ptr = 40'd0; end
                4'd1: begin eve_cmd = 8'h20; eve_ptr = {1'b0, base_q}; end
                4'd2: begin eve_cmd = 8'h21; eve_ptr = {24'd0, ph_width_q}; end
                4'd3: begin eve_cmd = 8'h22; eve_ptr = {24'd0, lo_width_q}; end
                4'd4: begin eve_cmd = 8'h23; eve_ptr = {24'd0, lo_height_q}; end
                4'd5: begin eve_cmd = 8'h24; eve_ptr = {38'd0, mode_q}; end
                4'd6: begin eve_cmd = 8'h27; eve_ptr = {39'd0, h_pol_q}; end
                4'd7: begin eve_cmd = 8'h28; eve_ptr = {39'd0, v_pol_q}; end
                4'd8: begin eve_cmd = 8'h25; eve_ptr = {39'd0, text_ena_q}; end
                default: begin eve_cmd = 8'h00; eve_ptr = 40'd0; end
            endcase
        end else if (state == TXT) begin
            eve_cmd = 8'h26;
            eve_ptr = {32'd0, fifo_mem[rd_ptr]};
        end
    end

endmodule
